cuckoo_hash_table: RTL and testbench

//   Parametrised two-way cuckoo hash table for the blockchain key store; supports SEARCH, INSERT (with

---
 rtl/cuckoo_hash_table.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_cuckoo_hash_table.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cuckoo_hash_table.sv
// Two-way cuckoo hash table with a bounded eviction chain; one operation in flight at a time.
// Define CUCKOO_STASH_EN to add a one-entry stash that absorbs the key left over on overflow.
module cuckoo_hash_table #(
  parameter int unsigned KEY_W     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_KICKS = 16,
  localparam int unsigned AW       = $clog2(DEPTH),
  localparam int unsigned KW       = $clog2(MAX_KICKS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [1:0]       op_code_i,
  input  logic [KEY_W-1:0] op_key_i,
  output logic             res_valid_o,
  output logic [1:0]       res_status_o,
  output logic [KEY_W-1:0] res_key_o,
  output logic [KW-1:0]    res_kicks_o,
  output logic [AW+1:0]    occupancy_o
);

  typedef enum logic [1:0] {StIdle, StLookup, StKick, StDone} state_e;

  localparam logic [1:0] OpInsert    = 2'b01;
  localparam logic [1:0] OpDelete    = 2'b10;
  localparam logic [1:0] ResOk       = 2'b00;
  localparam logic [1:0] ResNotFound = 2'b01;
  localparam logic [1:0] ResDup      = 2'b10;
  localparam logic [1:0] ResFail     = 2'b11;

  localparam logic [KW-1:0]   MaxKicks = KW'(MAX_KICKS);
  localparam logic [KW-1:0]   KickOne  = KW'(1);
  localparam logic [AW+1:0]   OccOne   = (AW + 2)'(1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] carry_q, carry_d;
  logic [KW-1:0]    kicks_q, kicks_d;
  logic             tgt_q, tgt_d;
  logic [1:0]       status_q, status_d;
  logic [KEY_W-1:0] rkey_q, rkey_d;
  logic [AW+1:0]    occ_q, occ_d;

  logic             res_valid_q;
  logic [1:0]       res_status_q;
  logic [KEY_W-1:0] res_key_q;
  logic [KW-1:0]    res_kicks_q;

  logic [KEY_W-1:0] t1_key_q [DEPTH];
  logic [KEY_W-1:0] t2_key_q [DEPTH];
  logic [DEPTH-1:0] t1_vld_q, t2_vld_q;

  // Table write/clear controls; a table is never written and cleared in the same cycle.
  logic             t1_set, t1_clr, t2_set, t2_clr;
  logic [AW-1:0]    t1_idx, t2_idx;
  logic [KEY_W-1:0] wr_key;
  logic             stash_set, stash_clr;
  logic             stash_hit, stash_free;

  // h2(k) = ((3*k) >> AW)[AW-1:0], product kept at KEY_W+2 bits.
  logic [KEY_W+1:0] key_x3, carry_x3;
  assign key_x3   = ({2'b00, key_q} + {1'b0, key_q, 1'b0}) >> AW;
  assign carry_x3 = ({2'b00, carry_q} + {1'b0, carry_q, 1'b0}) >> AW;

  logic unused_x3;
  assign unused_x3 = ^{key_x3[KEY_W+1:AW], carry_x3[KEY_W+1:AW]};

  logic [AW-1:0]    i1, i2, kidx;
  logic             hit1, hit2, any_hit;
  logic             kocc;
  logic [KEY_W-1:0] kslot;

  assign i1      = key_q[AW-1:0];
  assign i2      = key_x3[AW-1:0];
  assign hit1    = t1_vld_q[i1] && (t1_key_q[i1] == key_q);
  assign hit2    = t2_vld_q[i2] && (t2_key_q[i2] == key_q);
  assign any_hit = hit1 || hit2 || stash_hit;

  assign kidx  = tgt_q ? carry_x3[AW-1:0] : carry_q[AW-1:0];
  assign kocc  = tgt_q ? t2_vld_q[kidx] : t1_vld_q[kidx];
  assign kslot = tgt_q ? t2_key_q[kidx] : t1_key_q[kidx];

`ifdef CUCKOO_STASH_EN
  logic [KEY_W-1:0] stash_key_q;
  logic             stash_vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stash_key_q <= '0;
      stash_vld_q <= 1'b0;
    end else if (stash_set) begin
      stash_key_q <= carry_q;
      stash_vld_q <= 1'b1;
    end else if (stash_clr) begin
      stash_vld_q <= 1'b0;
    end
  end

  assign stash_hit  = stash_vld_q && (stash_key_q == key_q);
  assign stash_free = !stash_vld_q;
`else
  logic unused_stash;
  assign unused_stash = stash_set ^ stash_clr;
  assign stash_hit    = 1'b0;
  assign stash_free   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    key_d     = key_q;
    carry_d   = carry_q;
    kicks_d   = kicks_q;
    tgt_d     = tgt_q;
    status_d  = status_q;
    rkey_d    = rkey_q;
    occ_d     = occ_q;
    t1_set    = 1'b0;
    t1_clr    = 1'b0;
    t2_set    = 1'b0;
    t2_clr    = 1'b0;
    t1_idx    = i1;
    t2_idx    = i2;
    wr_key    = key_q;
    stash_set = 1'b0;
    stash_clr = 1'b0;

    case (state_q)
      StIdle: begin
        if (op_valid_i) begin
          op_d    = op_code_i;
          key_d   = op_key_i;
          kicks_d = '0;
          state_d = StLookup;
        end
      end

      StLookup: begin
        state_d = StDone;
        rkey_d  = key_q;
        case (op_q)
          OpInsert: begin
            if (any_hit) begin
              status_d = ResDup;
            end else if (!t1_vld_q[i1]) begin
              t1_set   = 1'b1;
              occ_d    = occ_q + OccOne;
              status_d = ResOk;
            end else if (!t2_vld_q[i2]) begin
              t2_set   = 1'b1;
              occ_d    = occ_q + OccOne;
              status_d = ResOk;
            end else begin
              // New key takes T1; the displaced entry starts the eviction chain toward T2.
              t1_set  = 1'b1;
              carry_d = t1_key_q[i1];
              kicks_d = KickOne;
              tgt_d   = 1'b1;
              state_d = StKick;
            end
          end
          OpDelete: begin
            status_d = ResOk;
            if (hit1) begin
              t1_clr = 1'b1;
              occ_d  = occ_q - OccOne;
            end else if (hit2) begin
              t2_clr = 1'b1;
              occ_d  = occ_q - OccOne;
            end else if (stash_hit) begin
              stash_clr = 1'b1;
              occ_d     = occ_q - OccOne;
            end else begin
              status_d = ResNotFound;
            end
          end
          default: status_d = any_hit ? ResOk : ResNotFound;
        endcase
      end

      StKick: begin
        wr_key = carry_q;
        t1_idx = kidx;
        t2_idx = kidx;
        if (!kocc) begin
          t1_set   = !tgt_q;
          t2_set   = tgt_q;
          occ_d    = occ_q + OccOne;
          status_d = ResOk;
          state_d  = StDone;
        end else if (kicks_q == MaxKicks) begin
          state_d = StDone;
          if (stash_free) begin
            stash_set = 1'b1;
            occ_d     = occ_q + OccOne;
            status_d  = ResOk;
          end else begin
            status_d = ResFail;
            rkey_d   = carry_q;
          end
        end else begin
          t1_set  = !tgt_q;
          t2_set  = tgt_q;
          carry_d = kslot;
          kicks_d = kicks_q + KickOne;
          tgt_d   = !tgt_q;
        end
      end

      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      t1_vld_q <= '0;
      t2_vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        t1_key_q[i] <= '0;
        t2_key_q[i] <= '0;
      end
    end else begin
      if (t1_set) begin
        t1_vld_q[t1_idx] <= 1'b1;
        t1_key_q[t1_idx] <= wr_key;
      end else if (t1_clr) begin
        t1_vld_q[t1_idx] <= 1'b0;
      end
      if (t2_set) begin
        t2_vld_q[t2_idx] <= 1'b1;
        t2_key_q[t2_idx] <= wr_key;
      end else if (t2_clr) begin
        t2_vld_q[t2_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      op_q         <= '0;
      key_q        <= '0;
      carry_q      <= '0;
      kicks_q      <= '0;
      tgt_q        <= 1'b0;
      status_q     <= '0;
      rkey_q       <= '0;
      occ_q        <= '0;
      res_valid_q  <= 1'b0;
      res_status_q <= '0;
      res_key_q    <= '0;
      res_kicks_q  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      key_q        <= key_d;
      carry_q      <= carry_d;
      kicks_q      <= kicks_d;
      tgt_q        <= tgt_d;
      status_q     <= status_d;
      rkey_q       <= rkey_d;
      occ_q        <= occ_d;
      // Result registers are loaded out of DONE and read as zero between pulses.
      res_valid_q  <= (state_q == StDone);
      res_status_q <= (state_q == StDone) ? status_q : '0;
      res_key_q    <= (state_q == StDone) ? rkey_q : '0;
      res_kicks_q  <= (state_q == StDone) ? kicks_q : '0;
    end
  end

  assign op_ready_o   = (state_q == StIdle);
  assign res_valid_o  = res_valid_q;
  assign res_status_o = res_status_q;
  assign res_key_o    = res_key_q;
  assign res_kicks_o  = res_kicks_q;
  assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_cuckoo_hash_table.sv
// Bench for cuckoo_hash_table: directed key scenarios plus randomized operations checked
// every cycle against a set-of-slots reference model (stash modelled when CUCKOO_STASH_EN).
module tb_cuckoo_hash_table;

  localparam int unsigned KEY_W = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAXK  = 2;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned KW    = $clog2(MAXK + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             op_valid = 1'b0;
  logic [1:0]       op_code = 2'b00;
  logic [KEY_W-1:0] op_key = '0;
  logic             op_ready, res_valid;
  logic [1:0]       res_status;
  logic [KEY_W-1:0] res_key;
  logic [KW-1:0]    res_kicks;
  logic [AW+1:0]    occupancy;

  always #5 clk = ~clk;

  cuckoo_hash_table #(
    .KEY_W    (KEY_W),
    .DEPTH    (DEPTH),
    .MAX_KICKS(MAXK)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_code_i   (op_code),
    .op_key_i    (op_key),
    .res_valid_o (res_valid),
    .res_status_o(res_status),
    .res_key_o   (res_key),
    .res_kicks_o (res_kicks),
    .occupancy_o (occupancy)
  );

  // Reference model: two tables of slots, plus an optional stash.
  bit [31:0] mk [2][DEPTH];
  bit        mv [2][DEPTH];
  bit [31:0] mst_k;
  bit        mst_v;

  int n_cmp = 0;
  int n_bad = 0;
  int pcyc  = 0;
  bit pend  = 1'b0;
  int acc_at, exp_at;
  bit [1:0]  e_st;
  bit [31:0] e_key;
  int        e_kicks;
  logic [1:0]  c_st;
  logic [31:0] c_key;
  int          c_kicks, c_lat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int mh(input int side, input bit [31:0] k);
    longint unsigned kk;
    kk = {32'b0, k};
    if (side == 0) return int'(kk % DEPTH);
    return int'(((kk * 3) >> AW) % DEPTH);
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < int'(DEPTH); i++) n += int'(mv[s][i]);
    return n + int'(mst_v);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < int'(DEPTH); i++) mv[s][i] = 1'b0;
    mst_v = 1'b0;
  endfunction

  function automatic void model_op(input bit [1:0] code, input bit [31:0] k,
                                   output bit [1:0] st, output bit [31:0] rk, output int kk);
    int ix [2];
    bit hit [2];
    bit hs;
    bit [31:0] carry, tmp;
    int side, idx;
    ix[0] = mh(0, k);
    ix[1] = mh(1, k);
    for (int s = 0; s < 2; s++) hit[s] = mv[s][ix[s]] && (mk[s][ix[s]] == k);
    hs = mst_v && (mst_k == k);
    st = 2'd0;
    rk = k;
    kk = 0;
    if (code == 2'b01) begin
      if (hit[0] || hit[1] || hs) st = 2'd2;
      else if (!mv[0][ix[0]]) begin mv[0][ix[0]] = 1'b1; mk[0][ix[0]] = k; end
      else if (!mv[1][ix[1]]) begin mv[1][ix[1]] = 1'b1; mk[1][ix[1]] = k; end
      else begin
        carry = mk[0][ix[0]];
        mk[0][ix[0]] = k;
        kk = 1;
        side = 1;
        for (int g = 0; g <= int'(MAXK); g++) begin
          idx = mh(side, carry);
          if (!mv[side][idx]) begin
            mv[side][idx] = 1'b1;
            mk[side][idx] = carry;
            break;
          end
          if (kk == int'(MAXK)) begin
`ifdef CUCKOO_STASH_EN
            if (!mst_v) begin mst_v = 1'b1; mst_k = carry; end
            else begin st = 2'd3; rk = carry; end
`else
            st = 2'd3;
            rk = carry;
`endif
            break;
          end
          tmp = mk[side][idx];
          mk[side][idx] = carry;
          carry = tmp;
          kk++;
          side = 1 - side;
        end
      end
    end else if (code == 2'b10) begin
      if (hit[0]) mv[0][ix[0]] = 1'b0;
      else if (hit[1]) mv[1][ix[1]] = 1'b0;
      else if (hs) mst_v = 1'b0;
      else st = 2'd1;
    end else begin
      st = (hit[0] || hit[1] || hs) ? 2'd0 : 2'd1;
    end
  endfunction

  initial forever begin
    @(posedge clk);
    pcyc++;
  end

  // Compare process: sampled on the falling edge, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_res_valid", res_valid, 0);
      chk("rst_occupancy", occupancy, 0);
    end else begin
      if (res_valid) begin
        if (!pend) chk("spurious_res_valid", res_valid, 0);
        else begin
          chk("res_latency", pcyc - acc_at, exp_at - acc_at);
          chk("res_status", res_status, e_st);
          chk("res_key", res_key, e_key);
          chk("res_kicks", res_kicks, e_kicks);
          chk("res_occupancy", occupancy, model_occ());
          c_st    = res_status;
          c_key   = res_key;
          c_kicks = int'(res_kicks);
          c_lat   = pcyc - acc_at;
          pend    = 1'b0;
        end
      end else if (pend && pcyc >= exp_at) begin
        chk("res_valid_missing", res_valid, 1);
        pend = 1'b0;
      end
      chk("op_ready", op_ready, !(pend && pcyc >= acc_at && pcyc < exp_at));
      if (!pend) chk("idle_occupancy", occupancy, model_occ());
    end
  end

  task automatic do_op(input bit [1:0] code, input bit [31:0] k, input bit noise);
    bit [1:0]  st;
    bit [31:0] rk;
    int        kk;
    @(posedge clk);
    #2;
    model_op(code, k, st, rk, kk);
    e_st     = st;
    e_key    = rk;
    e_kicks  = kk;
    acc_at   = pcyc + 1;
    exp_at   = pcyc + 3 + kk;
    pend     = 1'b1;
    op_valid = 1'b1;
    op_code  = code;
    op_key   = k;
    @(posedge clk);
    #2;
    // Requests raised while busy must be ignored.
    op_valid = noise;
    op_code  = 2'b01;
    op_key   = $urandom;
    while (pcyc < exp_at) begin
      @(posedge clk);
      #2;
    end
    op_valid = 1'b0;
    for (int i = 0; i < 8 && pend; i++) @(negedge clk);
  endtask

  bit [1:0]  rc;
  bit [31:0] rkey;
  int        r;

  initial begin
    model_clear();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_op_ready", op_ready, 1);
    chk("reset_res_status", res_status, 0);
    chk("reset_res_key", res_key, 0);
    chk("reset_res_kicks", res_kicks, 0);

    do_op(2'b00, 5, 0);
    chk("search5_status", c_st, 1);
    chk("search5_latency", c_lat, 2);
    chk("search5_occ", occupancy, 0);
    do_op(2'b01, 5, 0);
    chk("ins5_status", c_st, 0);
    chk("ins5_kicks", c_kicks, 0);
    do_op(2'b01, 13, 1);
    chk("ins13_status", c_st, 0);
    chk("ins13_kicks", c_kicks, 0);
    chk("ins13_occ", occupancy, 2);
    do_op(2'b01, 77, 0);
    chk("ins77_status", c_st, 0);
    chk("ins77_kicks", c_kicks, 1);
    chk("ins77_latency", c_lat, 3);
    do_op(2'b00, 5, 0);
    chk("search5_found", c_st, 0);
    do_op(2'b01, 77, 0);
    chk("ins77_dup", c_st, 2);
    do_op(2'b10, 13, 0);
    chk("del13_status", c_st, 0);
    chk("del13_occ", occupancy, 2);
    do_op(2'b00, 13, 0);
    chk("search13_nf", c_st, 1);
    do_op(2'b10, 13, 0);
    chk("del13_nf", c_st, 1);
    do_op(2'b01, 13, 1);
    chk("reins13_status", c_st, 0);
    do_op(2'b01, 141, 0);
    chk("ins141_kicks", c_kicks, 2);
    chk("ins141_latency", c_lat, 4);
`ifdef CUCKOO_STASH_EN
    chk("ins141_status", c_st, 0);
    chk("ins141_occ", occupancy, 4);
    do_op(2'b00, 13, 0);
    chk("search13_stash", c_st, 0);
`else
    chk("ins141_status", c_st, 3);
    chk("ins141_key", c_key, 13);
    chk("ins141_occ", occupancy, 3);
    do_op(2'b00, 13, 0);
    chk("search13_dropped", c_st, 1);
`endif
    do_op(2'b00, 77, 0);
    chk("search77_found", c_st, 0);
    do_op(2'b11, 141, 0);
    chk("reserved141_found", c_st, 0);

    // Reset while an insert of 205 (h1=5, h2=4) is in its eviction chain.
    @(posedge clk);
    #2;
    acc_at   = pcyc + 1;
    exp_at   = pcyc + 1000;
    pend     = 1'b1;
    op_valid = 1'b1;
    op_code  = 2'b01;
    op_key   = 205;
    @(posedge clk);
    #2;
    op_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pend  = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_reset_occ", occupancy, 0);
    do_op(2'b00, 5, 0);
    chk("post_reset_search5", c_st, 1);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      rc = (r < 9) ? 2'b01 : (r < 14) ? 2'b00 : (r < 19) ? 2'b10 : 2'b11;
      rkey = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 31));
      do_op(rc, rkey, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
